// File: rtl/mac_array_pkg.sv
// Shared definitions for the ternary systolic MAC array and its run sequencer.
package mac_array_pkg;

  localparam int SLICES     = 2;
  localparam int ARRAY_SIZE = 8;
  localparam int SLICE_W    = $clog2(SLICES);
  localparam int IDX_W      = $clog2(ARRAY_SIZE);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/run_counter.sv
// Loadable down-counter with a terminal-count flag; shared by the LOAD, FLUSH and DRAIN phases.
module run_counter #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  output logic         o_tc
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_tc = (r_count == '0);

endmodule

// File: rtl/mac_array_sequencer.sv
// Run controller for the ternary MAC array: sequences LOAD, FLUSH and DRAIN and drives the array strobes.
module mac_array_sequencer #(
  parameter int SLICES       = mac_array_pkg::SLICES,
  parameter int ARRAY_SIZE   = mac_array_pkg::ARRAY_SIZE,
  parameter int K_BITS       = 8,
  parameter int FLUSH_CYCLES = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          i_start,
  input  logic [K_BITS-1:0]             i_k_len,
  input  logic [2:0]                    i_shift_cfg,
  output logic                          o_busy,
  output logic                          o_in_accept,
  output logic [$clog2(SLICES)-1:0]     o_beat_slice,
  output logic                          o_force_zero_weights,
  output logic                          o_restart_inputs,
  output logic                          o_reset_accumulators,
  output logic                          o_copy_to_out_queue,
  output logic                          o_restart_out_queue,
  output logic [2:0]                    o_shift_amt,
  output logic                          o_out_valid,
  output logic [$clog2(ARRAY_SIZE)-1:0] o_out_index,
  output logic                          o_done,
  output mac_array_pkg::state_t         o_state
);

  import mac_array_pkg::*;

  localparam int SW     = $clog2(SLICES);
  localparam int IW     = $clog2(ARRAY_SIZE);
  localparam int BEAT_W = K_BITS + SW;
  localparam int CNT_W  = max_int(BEAT_W, max_int(IW, $clog2(FLUSH_CYCLES)));

  state_t           r_state;
  state_t           w_next_state;
  logic             w_tc;
  logic             w_accept;
  logic             w_cnt_load;
  logic             w_cnt_en;
  logic [CNT_W-1:0] w_cnt_val;
  logic [CNT_W-1:0] w_load_beats;
  logic [SW-1:0]    r_slice;
  logic [2:0]       r_shift;
  logic             r_out_valid;
  logic [IW-1:0]    r_out_index;

  assign w_load_beats = (CNT_W'(i_k_len) * CNT_W'(SLICES)) - CNT_W'(1);

  // A new run is taken only from IDLE or on the very last DRAIN cycle.
  assign w_accept = i_start && (i_k_len != '0) &&
                    ((r_state == ST_IDLE) || ((r_state == ST_DRAIN) && w_tc));

  always_comb begin
    w_next_state = r_state;
    w_cnt_load   = 1'b0;
    w_cnt_val    = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_next_state = ST_LOAD;
          w_cnt_load   = 1'b1;
          w_cnt_val    = w_load_beats;
        end
      end
      ST_LOAD: begin
        if (w_tc) begin
          w_next_state = ST_FLUSH;
          w_cnt_load   = 1'b1;
          w_cnt_val    = CNT_W'(FLUSH_CYCLES - 1);
        end
      end
      ST_FLUSH: begin
        if (w_tc) begin
          w_next_state = ST_DRAIN;
          w_cnt_load   = 1'b1;
          w_cnt_val    = CNT_W'(ARRAY_SIZE - 1);
        end
      end
      ST_DRAIN: begin
        if (w_tc) begin
          if (w_accept) begin
            w_next_state = ST_LOAD;
            w_cnt_load   = 1'b1;
            w_cnt_val    = w_load_beats;
          end else begin
            w_next_state = ST_IDLE;
          end
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  assign w_cnt_en = (r_state != ST_IDLE);

  run_counter #(
    .W (CNT_W)
  ) u_run_counter (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_cnt_load),
    .i_load_val (w_cnt_val),
    .i_en       (w_cnt_en),
    .o_tc       (w_tc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_slice     <= '0;
      r_shift     <= 3'd0;
      r_out_valid <= 1'b0;
      r_out_index <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_shift <= i_shift_cfg;
      end
      // Slice index restarts at 0 each run, matching the array's slice counter held by restart_inputs.
      if ((r_state == ST_LOAD) && (w_next_state == ST_LOAD)) begin
        r_slice <= (r_slice == SW'(SLICES - 1)) ? '0 : r_slice + SW'(1);
      end else begin
        r_slice <= '0;
      end
      r_out_valid <= (w_next_state == ST_DRAIN);
      if ((r_state == ST_DRAIN) && (w_next_state == ST_DRAIN)) begin
        r_out_index <= r_out_index + IW'(1);
      end else begin
        r_out_index <= '0;
      end
    end
  end

  // The final FLUSH cycle copies the accumulators out and clears them for the next run.
  assign o_copy_to_out_queue  = (r_state == ST_FLUSH) && w_tc;
  assign o_restart_out_queue  = o_copy_to_out_queue;
  assign o_restart_inputs     = (r_state == ST_IDLE) || (r_state == ST_DRAIN) || o_copy_to_out_queue;
  assign o_reset_accumulators = o_restart_inputs;
  assign o_busy               = (r_state != ST_IDLE);
  assign o_in_accept          = (r_state == ST_LOAD);
  assign o_force_zero_weights = (r_state != ST_LOAD);
  assign o_beat_slice         = r_slice;
  assign o_shift_amt          = r_shift;
  assign o_out_valid          = r_out_valid;
  assign o_out_index          = r_out_index;
  assign o_done               = r_out_valid && (r_out_index == IW'(ARRAY_SIZE - 1));
  assign o_state              = r_state;

endmodule

// File: tb/tb_mac_array_sequencer.sv
// Directed bench for mac_array_sequencer with a small behavioural model of the ternary array.
module tb_mac_array_sequencer;

  import mac_array_pkg::*;

  logic        clk;
  logic        reset;
  logic        start;
  logic [7:0]  k_len;
  logic [2:0]  shift_cfg;
  logic        busy, in_accept, beat_slice, force_zero, restart_inputs, reset_acc;
  logic        copy_oq, restart_oq, out_valid, done;
  logic [2:0]  shift_amt, out_index;
  state_t      dbg_state;

  int checks = 0;
  int errors = 0;

  // Array model: row r, slice s accumulates into index r*2+s; weights row0=+1, row1=-1, rest 0.
  logic signed [7:0]  act;
  logic signed [15:0] acc [8];
  logic signed [15:0] oq  [8];
  int                 wt  [4] = '{1, -1, 0, 0};
  logic [7:0]         out_byte;

  mac_array_sequencer dut (
    .clk                  (clk),
    .reset                (reset),
    .i_start              (start),
    .i_k_len              (k_len),
    .i_shift_cfg          (shift_cfg),
    .o_busy               (busy),
    .o_in_accept          (in_accept),
    .o_beat_slice         (beat_slice),
    .o_force_zero_weights (force_zero),
    .o_restart_inputs     (restart_inputs),
    .o_reset_accumulators (reset_acc),
    .o_copy_to_out_queue  (copy_oq),
    .o_restart_out_queue  (restart_oq),
    .o_shift_amt          (shift_amt),
    .o_out_valid          (out_valid),
    .o_out_index          (out_index),
    .o_done               (done),
    .o_state              (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (copy_oq === 1'b1) begin
      for (int i = 0; i < 8; i++) oq[i] <= acc[i];
    end
    if (reset_acc !== 1'b0) begin
      for (int i = 0; i < 8; i++) acc[i] <= '0;
    end else if (in_accept === 1'b1 && force_zero === 1'b0) begin
      for (int r = 0; r < 4; r++)
        acc[r*2 + int'(beat_slice)] <= acc[r*2 + int'(beat_slice)] + 16'(wt[r] * int'(act));
    end
  end

  assign out_byte = 8'(oq[out_index] >>> shift_amt);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [7:0] kl, input logic [2:0] sh);
    start = 1'b1; k_len = kl; shift_cfg = sh;
    step();
    start = 1'b0; k_len = 8'd0; shift_cfg = 3'd0;
  endtask

  task automatic test_reset();
    for (int c = 0; c < 5; c++) begin
      checks++;
      if ({restart_inputs, reset_acc, force_zero, busy, out_valid, done, copy_oq, in_accept} !== 8'b11100000) begin
        errors++;
        $display("FAIL reset_idle cycle %0d got=%b exp=11100000", c,
                 {restart_inputs, reset_acc, force_zero, busy, out_valid, done, copy_oq, in_accept});
      end
      step();
    end
    checks++;
    if (shift_amt !== 3'd0 || dbg_state !== ST_IDLE) begin
      errors++;
      $display("FAIL reset_regs got shift=%0d state=%0d exp shift=0 state=0", shift_amt, dbg_state);
    end
  endtask

  task automatic test_single_run();
    launch(8'd1, 3'd3);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({in_accept, busy, force_zero, restart_inputs, reset_acc} !== 5'b11000 || beat_slice !== 1'(i)) begin
        errors++;
        $display("FAIL single_load beat %0d got=%b slice=%b exp=11000 slice=%0d", i,
                 {in_accept, busy, force_zero, restart_inputs, reset_acc}, beat_slice, i);
      end
      step();
    end
    for (int f = 0; f < 3; f++) begin
      checks++;
      if ({in_accept, force_zero, copy_oq, restart_oq, restart_inputs, reset_acc} !==
          ((f == 2) ? 6'b011111 : 6'b010000)) begin
        errors++;
        $display("FAIL single_flush cycle %0d got=%b exp=%b", f,
                 {in_accept, force_zero, copy_oq, restart_oq, restart_inputs, reset_acc},
                 (f == 2) ? 6'b011111 : 6'b010000);
      end
      step();
    end
    for (int d = 0; d < 8; d++) begin
      checks++;
      if (out_valid !== 1'b1 || out_index !== 3'(d) || done !== (d == 7) ||
          {restart_inputs, reset_acc} !== 2'b11 || shift_amt !== 3'd3) begin
        errors++;
        $display("FAIL single_drain cycle %0d got v=%b idx=%0d done=%b ri_ra=%b sh=%0d exp v=1 idx=%0d done=%0d ri_ra=11 sh=3",
                 d, out_valid, out_index, done, {restart_inputs, reset_acc}, shift_amt, d, (d == 7));
      end
      step();
    end
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0 || shift_amt !== 3'd3) begin
      errors++;
      $display("FAIL single_end got busy=%b v=%b done=%b sh=%0d exp busy=0 v=0 done=0 sh=3",
               busy, out_valid, done, shift_amt);
    end
  endtask

  task automatic test_array_cosim();
    logic [7:0] acts [4];
    logic [7:0] exp_out [8];
    acts    = '{8'd10, 8'd20, 8'd5, 8'd7};
    exp_out = '{8'd15, 8'd27, 8'hF1, 8'hE5, 8'd0, 8'd0, 8'd0, 8'd0};
    launch(8'd2, 3'd0);
    for (int i = 0; i < 4; i++) begin
      act = acts[i];
      checks++;
      if (in_accept !== 1'b1 || beat_slice !== 1'(i % 2)) begin
        errors++;
        $display("FAIL cosim_load beat %0d got acc=%b slice=%b exp acc=1 slice=%0d", i, in_accept, beat_slice, i % 2);
      end
      step();
    end
    act = '0;
    checks++;
    if (in_accept !== 1'b0 || dbg_state !== ST_FLUSH) begin
      errors++;
      $display("FAIL cosim_len got in_accept=%b state=%0d exp in_accept=0 state=2", in_accept, dbg_state);
    end
    repeat (3) step();
    for (int d = 0; d < 8; d++) begin
      checks++;
      if (out_valid !== 1'b1 || out_byte !== exp_out[d]) begin
        errors++;
        $display("FAIL cosim_drain idx %0d got v=%b byte=%0d exp v=1 byte=%0d", d, out_valid, out_byte, exp_out[d]);
      end
      step();
    end
  endtask

  task automatic test_ignored_starts();
    start = 1'b1; k_len = 8'd0; shift_cfg = 3'd6;
    step();
    start = 1'b0;
    checks++;
    if (busy !== 1'b0 || in_accept !== 1'b0 || shift_amt === 3'd6) begin
      errors++;
      $display("FAIL ignore_zero got busy=%b in_accept=%b sh=%0d exp busy=0 in_accept=0 sh!=6", busy, in_accept, shift_amt);
    end
    launch(8'd1, 3'd2);
    start = 1'b1; k_len = 8'd5; shift_cfg = 3'd7;
    step();
    start = 1'b0;
    checks++;
    if (in_accept !== 1'b1 || beat_slice !== 1'b1) begin
      errors++;
      $display("FAIL ignore_load_beat1 got in_accept=%b slice=%b exp 1 1", in_accept, beat_slice);
    end
    step();
    checks++;
    if (dbg_state !== ST_FLUSH || shift_amt !== 3'd2) begin
      errors++;
      $display("FAIL ignore_load_len got state=%0d sh=%0d exp state=2 sh=2", dbg_state, shift_amt);
    end
    repeat (3) step();
    for (int d = 0; d < 8; d++) begin
      if (d == 3) begin
        start = 1'b1; k_len = 8'd3; shift_cfg = 3'd5;
      end
      checks++;
      if (out_valid !== 1'b1 || out_index !== 3'(d)) begin
        errors++;
        $display("FAIL ignore_drain idx %0d got v=%b idx=%0d exp v=1 idx=%0d", d, out_valid, out_index, d);
      end
      step();
      start = 1'b0;
    end
    checks++;
    if (busy !== 1'b0 || dbg_state !== ST_IDLE || shift_amt !== 3'd2) begin
      errors++;
      $display("FAIL ignore_end got busy=%b state=%0d sh=%0d exp busy=0 state=0 sh=2", busy, dbg_state, shift_amt);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp1 [4];
    logic [7:0] exp2 [4];
    exp1 = '{8'd3, 8'd4, 8'hFD, 8'hFC};
    exp2 = '{8'd6, 8'd9, 8'hFA, 8'hF7};
    launch(8'd1, 3'd0);
    act = 8'sd3; step();
    act = 8'sd4; step();
    act = '0;
    repeat (3) step();
    for (int d = 0; d < 8; d++) begin
      checks++;
      if (out_byte !== ((d < 4) ? exp1[d] : 8'd0)) begin
        errors++;
        $display("FAIL b2b_run1 idx %0d got=%0d exp=%0d", d, out_byte, (d < 4) ? exp1[d] : 8'd0);
      end
      if (d == 7) begin
        start = 1'b1; k_len = 8'd1; shift_cfg = 3'd0;
      end
      step();
    end
    start = 1'b0; k_len = 8'd0;
    checks++;
    if (in_accept !== 1'b1 || beat_slice !== 1'b0 || dbg_state !== ST_LOAD) begin
      errors++;
      $display("FAIL b2b_no_idle got in_accept=%b slice=%b state=%0d exp 1 0 1", in_accept, beat_slice, dbg_state);
    end
    act = 8'sd6; step();
    act = 8'sd9; step();
    act = '0;
    repeat (3) step();
    for (int d = 0; d < 4; d++) begin
      checks++;
      if (out_valid !== 1'b1 || out_byte !== exp2[d]) begin
        errors++;
        $display("FAIL b2b_run2 idx %0d got v=%b byte=%0d exp v=1 byte=%0d", d, out_valid, out_byte, exp2[d]);
      end
      step();
    end
    repeat (4) step();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end got busy=%b exp 0", busy);
    end
  endtask

  task automatic test_midrun_reset();
    launch(8'd1, 3'd5);
    repeat (3) step();
    checks++;
    if (dbg_state !== ST_FLUSH || copy_oq !== 1'b0) begin
      errors++;
      $display("FAIL midreset_pre got state=%0d copy=%b exp state=2 copy=0", dbg_state, copy_oq);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if ({busy, restart_inputs, reset_acc, force_zero, out_valid} !== 5'b01110 || shift_amt !== 3'd0 ||
        dbg_state !== ST_IDLE) begin
      errors++;
      $display("FAIL midreset_post got=%b sh=%0d state=%0d exp=01110 sh=0 state=0",
               {busy, restart_inputs, reset_acc, force_zero, out_valid}, shift_amt, dbg_state);
    end
    for (int c = 0; c < 12; c++) begin
      checks++;
      if (copy_oq !== 1'b0 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL midreset_quiet cycle %0d got copy=%b v=%b exp 0 0", c, copy_oq, out_valid);
      end
      step();
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; k_len = 8'd0; shift_cfg = 3'd0; act = '0;
    step();
    step();
    reset = 1'b0;
    test_reset();
    test_single_run();
    test_array_cosim();
    test_ignored_starts();
    test_back_to_back();
    test_midrun_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
